// File: rtl/wired_lsu_mem_bridge.sv
// LSU responder bridge: classifies LSU issue-queue requests, answers
// misaligned / barrier / cache-op / failed-SC requests locally, forwards the
// rest to an in-order word-wide memory bus, and returns responses in program
// order through a small tracking queue.

`ifndef _ECODE_ALE
`define _ECODE_ALE 6'h09
`endif

package wired_lsu_pkg;

  typedef enum logic [1:0] {
    CACOP_RD_ALLOC = 2'd0,
    CACOP_WR_ALLOC = 2'd1,
    CACOP_IDX_INV  = 2'd2,
    CACOP_HIT_INV  = 2'd3
  } cacop_e;

  localparam logic [5:0] ECODE_ALE = `_ECODE_ALE;

  typedef struct packed {
    logic       valid;
    logic [5:0] ecode;
    logic [8:0] subcode;
  } excp_t;

  typedef struct packed {
    logic [4:0]  wid;
    logic [31:0] vaddr;
    logic [1:0]  msize;
    logic        msigned;
    logic [3:0]  strb;
    logic [31:0] wdata;
    cacop_e      cacop;
    logic        dbar;
    logic        llsc;
  } iq_lsu_req_t;

  typedef struct packed {
    excp_t       excp;
    logic [31:0] vaddr;
    logic        uncached;
    logic        wrong_forward;
    logic [31:0] rdata;
    logic [4:0]  wid;
  } iq_lsu_resp_t;

endpackage

module wired_lsu_mem_bridge
  import wired_lsu_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lsu_req_valid_i,
  output logic         lsu_req_ready_o,
  input  iq_lsu_req_t  lsu_req_i,
  output logic         lsu_resp_valid_o,
  input  logic         lsu_resp_ready_i,
  output iq_lsu_resp_t lsu_resp_o,
  output logic         mem_req_valid_o,
  input  logic         mem_req_ready_i,
  output logic [31:0]  mem_addr_o,
  output logic         mem_we_o,
  output logic [3:0]   mem_strb_o,
  output logic [31:0]  mem_wdata_o,
  input  logic         mem_resp_valid_i,
  input  logic [31:0]  mem_rdata_i
);

  localparam int unsigned PW = $clog2(OUTSTANDING);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  typedef struct packed {
    logic [4:0]  wid;
    logic [31:0] vaddr;
    logic [1:0]  msize;
    logic        msigned;
    logic        llsc;
    logic        write;
    logic        ale;
    logic        done;
    logic [31:0] rdata;
  } entry_t;

  entry_t q [OUTSTANDING];

  ptr_t head_q, tail_q;
  cnt_t cnt_q, inflight_q;
  logic llbit_q;

  logic req_write, req_alloc, req_ale, req_fail_sc, req_local, req_mem;
  logic full, accept, deq;
  entry_t new_entry;

  ptr_t        resp_idx;
  ptr_t        scan_idx;
  logic        scan_found;
  logic [31:0] sh_data;
  logic [31:0] proc_rdata;

  // Request classification from the incoming request and the current llbit
  always_comb begin
    req_write   = |lsu_req_i.strb;
    req_alloc   = (lsu_req_i.cacop == CACOP_RD_ALLOC) ||
                  (lsu_req_i.cacop == CACOP_WR_ALLOC);
    req_ale     = req_alloc &&
                  (((lsu_req_i.msize == 2'd1) && lsu_req_i.vaddr[0]) ||
                   ((lsu_req_i.msize == 2'd2) && (lsu_req_i.vaddr[1:0] != 2'b00)));
    req_fail_sc = lsu_req_i.llsc && req_write && !llbit_q;
    req_local   = req_ale || lsu_req_i.dbar || !req_alloc || req_fail_sc;
    req_mem     = !req_local;
  end

  // Request-side handshake; memory request and acceptance share one cycle
  always_comb begin
    full            = (cnt_q == cnt_t'(OUTSTANDING));
    mem_req_valid_o = lsu_req_valid_i && req_mem && !full;
    if (full)
      lsu_req_ready_o = 1'b0;
    else if (req_mem)
      lsu_req_ready_o = mem_req_ready_i;
    else if (lsu_req_i.dbar)
      lsu_req_ready_o = (inflight_q == '0);
    else
      lsu_req_ready_o = 1'b1;
    accept      = lsu_req_valid_i && lsu_req_ready_o;
    mem_addr_o  = {lsu_req_i.vaddr[31:2], 2'b00};
    mem_we_o    = req_write;
    mem_strb_o  = lsu_req_i.strb;
    mem_wdata_o = lsu_req_i.wdata;
  end

  // Entry image written at the tail on acceptance
  always_comb begin
    new_entry         = '0;
    new_entry.wid     = lsu_req_i.wid;
    new_entry.vaddr   = lsu_req_i.vaddr;
    new_entry.msize   = lsu_req_i.msize;
    new_entry.msigned = lsu_req_i.msigned;
    new_entry.llsc    = lsu_req_i.llsc;
    new_entry.write   = req_write;
    new_entry.ale     = req_ale;
    new_entry.done    = req_local;
    new_entry.rdata   = '0;
  end

  // Oldest not-done entry: memory answers in order, but local entries are
  // interleaved, so scan forward from head within the occupied range.
  always_comb begin
    resp_idx   = head_q;
    scan_found = 1'b0;
    scan_idx   = head_q;
    for (int unsigned i = 0; i < OUTSTANDING; i++) begin
      scan_idx = head_q + ptr_t'(i);
      if (!scan_found && (cnt_t'(i) < cnt_q) && !q[scan_idx].done) begin
        resp_idx   = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  // Load-data extraction and store / SC result for the completing entry
  always_comb begin
    sh_data = mem_rdata_i >> {q[resp_idx].vaddr[1:0], 3'b000};
    case (q[resp_idx].msize)
      2'd0:    proc_rdata = q[resp_idx].msigned ? {{24{sh_data[7]}}, sh_data[7:0]}
                                                : {24'b0, sh_data[7:0]};
      2'd1:    proc_rdata = q[resp_idx].msigned ? {{16{sh_data[15]}}, sh_data[15:0]}
                                                : {16'b0, sh_data[15:0]};
      default: proc_rdata = sh_data;
    endcase
    if (q[resp_idx].write)
      proc_rdata = q[resp_idx].llsc ? 32'd1 : '0;
  end

  // Head entry drives the response
  always_comb begin
    lsu_resp_valid_o         = (cnt_q != '0) && q[head_q].done;
    deq                      = lsu_resp_valid_o && lsu_resp_ready_i;
    lsu_resp_o               = '0;
    lsu_resp_o.wid           = q[head_q].wid;
    lsu_resp_o.vaddr         = q[head_q].vaddr;
    lsu_resp_o.rdata         = q[head_q].rdata;
    lsu_resp_o.excp.valid    = q[head_q].ale;
    lsu_resp_o.excp.ecode    = q[head_q].ale ? ECODE_ALE : 6'd0;
    lsu_resp_o.excp.subcode  = '0;
    lsu_resp_o.uncached      = 1'b0;
    lsu_resp_o.wrong_forward = 1'b0;
  end

  // Queue pointers, counters, entry completion and llbit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= '0;
      llbit_q    <= 1'b0;
      for (int unsigned i = 0; i < OUTSTANDING; i++)
        q[i].done <= 1'b0;
    end else begin
      if (accept) begin
        q[tail_q] <= new_entry;
        tail_q    <= tail_q + ptr_t'(1);
        if (lsu_req_i.llsc && req_write)
          llbit_q <= 1'b0;
        else if (lsu_req_i.llsc && req_mem)
          llbit_q <= 1'b1;
      end
      if (mem_resp_valid_i) begin
        q[resp_idx].done  <= 1'b1;
        q[resp_idx].rdata <= proc_rdata;
      end
      if (deq)
        head_q <= head_q + ptr_t'(1);
      cnt_q      <= cnt_q + cnt_t'(accept) - cnt_t'(deq);
      inflight_q <= inflight_q + cnt_t'(accept && req_mem) - cnt_t'(mem_resp_valid_i);
    end
  end

  a_mem_resp_has_inflight: assert property (
    @(posedge clk) disable iff (!rst_n) !(mem_resp_valid_i && (inflight_q == '0)));

endmodule

// File: tb/tb_wired_lsu_mem_bridge.sv
// Scoreboard bench for wired_lsu_mem_bridge: expected responses are queued at
// request acceptance from a reference model and compared in order at output.

`timescale 1ns/1ps

module tb_wired_lsu_mem_bridge;
  import wired_lsu_pkg::*;

  localparam int unsigned OUTSTANDING = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lsu_req_valid_i = 1'b0;
  logic         lsu_req_ready_o;
  iq_lsu_req_t  lsu_req_i;
  logic         lsu_resp_valid_o;
  logic         lsu_resp_ready_i;
  iq_lsu_resp_t lsu_resp_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b1;
  logic [31:0]  mem_addr_o;
  logic         mem_we_o;
  logic [3:0]   mem_strb_o;
  logic [31:0]  mem_wdata_o;
  logic         mem_resp_valid_i;
  logic [31:0]  mem_rdata_i;

  wired_lsu_mem_bridge #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lsu_req_valid_i  (lsu_req_valid_i),
    .lsu_req_ready_o  (lsu_req_ready_o),
    .lsu_req_i        (lsu_req_i),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_ready_i (lsu_resp_ready_i),
    .lsu_resp_o       (lsu_resp_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_we_o         (mem_we_o),
    .mem_strb_o       (mem_strb_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  wid;
    logic [31:0] vaddr;
    logic [31:0] rdata;
    logic        ale;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] pend_q[$];
  logic        mem_hold = 1'b0;
  logic        resp_toggle = 1'b0;
  int          mem_resp_seen = 0;
  logic        tb_llbit = 1'b0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory model: capture accepted requests, apply writes at acceptance
  logic [31:0] mw;
  always @(negedge clk) begin
    if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
      mw = rd_word(mem_addr_o);
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_strb_o[b]) mw[8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem_m[mem_addr_o] = mw;
        pend_q.push_back(32'hDEAD_BEEF);
      end else begin
        pend_q.push_back(mw);
      end
    end
  end

  // Memory responder: one pulse per pending request unless held
  initial begin
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = '0;
    forever begin
      @(posedge clk);
      if (mem_resp_valid_i) mem_resp_seen++;
      #1;
      mem_resp_valid_i = 1'b0;
      if (!mem_hold && pend_q.size() > 0) begin
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = pend_q.pop_front();
      end
    end
  end

  // Response-ready driver, optionally toggling
  initial begin
    lsu_resp_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      lsu_resp_ready_i = resp_toggle ? ~lsu_resp_ready_i : 1'b1;
    end
  end

  // Response monitor: pop and compare in order
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && lsu_resp_valid_o && lsu_resp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_wid", 32'(lsu_resp_o.wid), 32'(mon_e.wid));
        chk("resp_vaddr", lsu_resp_o.vaddr, mon_e.vaddr);
        chk("resp_rdata", lsu_resp_o.rdata, mon_e.rdata);
        chk("resp_excp_valid", 32'(lsu_resp_o.excp.valid), 32'(mon_e.ale));
        chk("resp_excp_ecode", 32'(lsu_resp_o.excp.ecode), mon_e.ale ? 32'(ECODE_ALE) : 32'd0);
        chk("resp_flags", {30'd0, lsu_resp_o.uncached, lsu_resp_o.wrong_forward}, 32'd0);
      end
    end
  end

  task automatic drive_req(input logic [4:0] wid, input logic [31:0] vaddr,
                           input logic [1:0] msize, input logic msigned,
                           input logic [3:0] strb, input logic [31:0] wdata,
                           input cacop_e cacop, input logic dbar, input logic llsc);
    lsu_req_i.wid     = wid;
    lsu_req_i.vaddr   = vaddr;
    lsu_req_i.msize   = msize;
    lsu_req_i.msigned = msigned;
    lsu_req_i.strb    = strb;
    lsu_req_i.wdata   = wdata;
    lsu_req_i.cacop   = cacop;
    lsu_req_i.dbar    = dbar;
    lsu_req_i.llsc    = llsc;
  endtask

  // Reference model evaluated at the acceptance edge; pushes the expectation
  task automatic model_accept(input string tag);
    logic write, alloc, ale, loc;
    logic [31:0] w;
    int base;
    exp_t e;
    write = |lsu_req_i.strb;
    alloc = (lsu_req_i.cacop == CACOP_RD_ALLOC) || (lsu_req_i.cacop == CACOP_WR_ALLOC);
    ale   = alloc && ((lsu_req_i.msize == 2'd1 && lsu_req_i.vaddr[0]) ||
                      (lsu_req_i.msize == 2'd2 && lsu_req_i.vaddr[1:0] != 2'b00));
    loc   = ale || lsu_req_i.dbar || !alloc || (lsu_req_i.llsc && write && !tb_llbit);
    chk({tag, "_mem_valid"}, 32'(mem_req_valid_o), 32'(!loc));
    e.wid   = lsu_req_i.wid;
    e.vaddr = lsu_req_i.vaddr;
    e.ale   = ale;
    e.rdata = '0;
    if (!loc) begin
      chk({tag, "_mem_addr"}, mem_addr_o, {lsu_req_i.vaddr[31:2], 2'b00});
      chk({tag, "_mem_we"}, 32'(mem_we_o), 32'(write));
      chk({tag, "_mem_strb"}, 32'(mem_strb_o), 32'(lsu_req_i.strb));
      if (write) begin
        e.rdata = lsu_req_i.llsc ? 32'd1 : 32'd0;
      end else begin
        w    = rd_word({lsu_req_i.vaddr[31:2], 2'b00});
        base = 8 * int'(lsu_req_i.vaddr[1:0]);
        case (lsu_req_i.msize)
          2'd0: begin
            e.rdata = {24'd0, w[base +: 8]};
            if (lsu_req_i.msigned && w[base + 7]) e.rdata[31:8] = '1;
          end
          2'd1: begin
            e.rdata = {16'd0, w[base +: 16]};
            if (lsu_req_i.msigned && w[base + 15]) e.rdata[31:16] = '1;
          end
          default: e.rdata = w;
        endcase
      end
    end
    if (lsu_req_i.llsc && write) tb_llbit = 1'b0;
    else if (lsu_req_i.llsc && !loc) tb_llbit = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic send(input string tag, input logic [4:0] wid, input logic [31:0] vaddr,
                      input logic [1:0] msize, input logic msigned, input logic [3:0] strb,
                      input logic [31:0] wdata, input cacop_e cacop, input logic dbar,
                      input logic llsc);
    bit acc;
    acc = 1'b0;
    drive_req(wid, vaddr, msize, msigned, strb, wdata, cacop, dbar, llsc);
    lsu_req_valid_i = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (lsu_req_ready_o) begin
        model_accept(tag);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    lsu_req_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [1:0]  lt_size [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  logic        lt_sign [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0]  lt_off  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};

  initial begin
    bit acc;
    int base_seen;
    lsu_req_i = '0;
    mem_m[32'h0000_1000] = 32'h80FF_FF11;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp_valid", 32'(lsu_resp_valid_o), 32'd0);
    chk("reset_mem_valid", 32'(mem_req_valid_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed byte load from the top byte lane
    send("lb", 5'd1, 32'h0000_1003, 2'd0, 1'b1, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    wait_drain("lb");

    // Size/sign/offset sweep on the same word
    for (int i = 0; i < 5; i++)
      send("ld_sweep", 5'(i + 2), 32'h0000_1000 | 32'(lt_off[i]), lt_size[i], lt_sign[i],
           4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    send("sh", 5'd8, 32'h0000_1100, 2'd1, 1'b0, 4'hC, 32'hBEEF_0000, CACOP_WR_ALLOC, 1'b0, 1'b0);
    send("lw_after_sh", 5'd9, 32'h0000_1100, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    wait_drain("sweep");

    // Misaligned half: local ALE response next cycle, then a word load
    send("ale", 5'd10, 32'h0000_2001, 2'd1, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    chk("ale_latency", 32'(lsu_resp_valid_o), 32'd1);
    send("lw_after_ale", 5'd11, 32'h0000_2004, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    wait_drain("ale");

    // LL then successful SC, then a failing SC
    send("ll", 5'd12, 32'h0000_3000, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b1);
    send("sc_ok", 5'd13, 32'h0000_3000, 2'd2, 1'b0, 4'hF, 32'h1234_5678, CACOP_WR_ALLOC, 1'b0, 1'b1);
    send("sc_fail", 5'd14, 32'h0000_3000, 2'd2, 1'b0, 4'hF, 32'h9999_0000, CACOP_WR_ALLOC, 1'b0, 1'b1);
    wait_drain("llsc");

    // Memory back-pressure stalls acceptance
    mem_req_ready_i = 1'b0;
    drive_req(5'd15, 32'h0000_1000, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    lsu_req_valid_i = 1'b1;
    @(negedge clk);
    chk("memstall_ready", 32'(lsu_req_ready_o), 32'd0);
    chk("memstall_mem_valid", 32'(mem_req_valid_o), 32'd1);
    @(posedge clk);
    #1;
    mem_req_ready_i = 1'b1;
    send("memstall", 5'd15, 32'h0000_1000, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    wait_drain("memstall");

    // Fill the queue with memory responses withheld
    mem_hold = 1'b1;
    for (int i = 0; i < 4; i++)
      send("fill", 5'(16 + i), 32'h0000_4000 + 32'(4 * i), 2'd2, 1'b0, 4'h0, '0,
           CACOP_RD_ALLOC, 1'b0, 1'b0);
    drive_req(5'd20, 32'h0000_4010, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    lsu_req_valid_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("full_ready", 32'(lsu_req_ready_o), 32'd0);
      chk("full_mem_valid", 32'(mem_req_valid_o), 32'd0);
      chk("held_resp_valid", 32'(lsu_resp_valid_o), 32'd0);
      @(posedge clk);
      #1;
    end
    lsu_req_valid_i = 1'b0;
    resp_toggle = 1'b1;
    mem_hold = 1'b0;
    wait_drain("fill");
    resp_toggle = 1'b0;
    @(posedge clk);
    #1;
    send("fifth", 5'd20, 32'h0000_4010, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    wait_drain("fifth");

    // Completed local entry waits behind an older pending load
    mem_hold = 1'b1;
    send("ord_ld", 5'd21, 32'h0000_7000, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    send("ord_cacop", 5'd22, 32'h0000_7040, 2'd2, 1'b0, 4'h0, '0, CACOP_IDX_INV, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("order_hold", 32'(lsu_resp_valid_o), 32'd0);
    end
    @(posedge clk);
    #1;
    mem_hold = 1'b0;
    wait_drain("order");

    // dbar behind two stores: ready only once both stores have completed
    mem_hold = 1'b1;
    send("st0", 5'd23, 32'h0000_5000, 2'd2, 1'b0, 4'hF, 32'hAAAA_0001, CACOP_WR_ALLOC, 1'b0, 1'b0);
    send("st1", 5'd24, 32'h0000_5004, 2'd2, 1'b0, 4'hF, 32'hAAAA_0002, CACOP_WR_ALLOC, 1'b0, 1'b0);
    base_seen = mem_resp_seen;
    drive_req(5'd25, 32'h0000_0000, 2'd0, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b1, 1'b0);
    lsu_req_valid_i = 1'b1;
    @(negedge clk);
    chk("dbar_blocked", 32'(lsu_req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    mem_hold = 1'b0;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      chk("dbar_ready", 32'(lsu_req_ready_o), 32'(mem_resp_seen - base_seen == 2));
      if (lsu_req_ready_o) begin
        model_accept("dbar");
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("dbar_accept_timeout", 32'd0, 32'd1);
    lsu_req_valid_i = 1'b0;
    wait_drain("dbar");

    // Reset with three entries queued discards them and clears llbit
    mem_hold = 1'b1;
    send("rst_ll", 5'd26, 32'h0000_6000, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b1);
    send("rst_ld0", 5'd27, 32'h0000_6004, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    send("rst_ld1", 5'd28, 32'h0000_6008, 2'd2, 1'b0, 4'h0, '0, CACOP_RD_ALLOC, 1'b0, 1'b0);
    lsu_req_i = '0;
    rst_n = 1'b0;
    pend_q.delete();
    exp_q.delete();
    tb_llbit = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_resp_valid", 32'(lsu_resp_valid_o), 32'd0);
    chk("midrst_req_ready", 32'(lsu_req_ready_o), 32'd1);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    @(posedge clk);
    #1;
    send("sc_after_rst", 5'd29, 32'h0000_6000, 2'd2, 1'b0, 4'hF, 32'h5555_5555, CACOP_WR_ALLOC, 1'b0, 1'b1);
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++)
      send("post_rst", 5'(30 + i), 32'h0000_6100 + 32'(4 * i), 2'd2, 1'b0, 4'h0, '0,
           CACOP_RD_ALLOC, 1'b0, 1'b0);
    mem_hold = 1'b0;
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wired_lsu_mem_bridge.md
Name: wired_lsu_mem_bridge

Overview:
- Responder end of the LSU issue-queue request/response interface: accepts `iq_lsu_req_t` requests and returns in-order `iq_lsu_resp_t` responses.
- Performs alignment checks, LL/SC bookkeeping and load-data extraction, and drives a simple in-order word-wide memory bus.
- Sits between the LSU issue queue and the data memory/cache model.
- Requests that need no memory access (misaligned, dbar, non-alloc cacop, failed SC) are answered locally, without breaking response order.

Parameters:
- OUTSTANDING, 4, depth of the in-order tracking queue; max requests accepted but not yet responded (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- lsu_req_valid_i  in  1  request valid
- lsu_req_ready_o  out  1  request accepted when valid&ready
- lsu_req_i  in  $bits(iq_lsu_req_t)  request fields: wid, vaddr, msize, msigned, strb, wdata, cacop, dbar, llsc
- lsu_resp_valid_o  out  1  response valid
- lsu_resp_ready_i  in  1  response consumed when valid&ready
- lsu_resp_o  out  $bits(iq_lsu_resp_t)  response fields: excp, vaddr, uncached, wrong_forward, rdata, wid
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request accepted
- mem_addr_o  out  32  word-aligned address {vaddr[31:2],2'b0}
- mem_we_o  out  1  write enable (strb≠0)
- mem_strb_o  out  4  byte strobes (lsu_req_i.strb)
- mem_wdata_o  out  32  lsu_req_i.wdata (pre-shifted)
- mem_resp_valid_i  in  1  one pulse per accepted mem request, in order, ≥1 cycle after acceptance, no backpressure
- mem_rdata_i  in  32  read word (ignored for writes)

Behaviour:
- Reset: rst_n is synchronous, active-low, on clk. Clears queue pointers/count, all entry done flags and llbit. Afterwards lsu_resp_valid_o=0 and mem_req_valid_o=0; lsu_req_ready_o follows its combinational equation.
- Classification, evaluated combinationally on lsu_req_i:
  - ale = (msize==1 & vaddr[0]) | (msize==2 & vaddr[1:0]≠0), only when cacop ∈ {RD_ALLOC, WR_ALLOC}.
  - local = ale | dbar | cacop∉{RD_ALLOC, WR_ALLOC} | (llsc & write & !llbit).
  - mem = !local.
- Handshake:
  - full = (cnt==OUTSTANDING).
  - mem_req_valid_o = lsu_req_valid_i & mem & !full.
  - lsu_req_ready_o = !full & (mem ? mem_req_ready_i : (dbar ? inflight==0 : 1)).
  - inflight = number of queued entries with done=0.
  - No registered stage on the request side: mem request and acceptance happen in the same cycle.
- Enqueue on accept at tail. Each entry stores wid, vaddr, msize, msigned, llsc, write, ale, done, rdata.
  - Local entries enqueue with done=1 and rdata as follows:
    - ale: rdata=0, excp = ALE (valid=1, ecode `_ECODE_ALE`, subcode 0).
    - failed SC: rdata=0, no excp.
    - dbar/cacop: rdata=0, no excp.
  - Mem entries enqueue with done=0.
- Memory response: mem_resp_valid_i marks the oldest not-done entry done and captures processed rdata:
  - Load: sh = mem_rdata_i >> {vaddr[1:0],3'b0}; byte → sign/zero-extend sh[7:0] per msigned; half → sh[15:0]; word → sh.
  - Store: rdata = 0.
  - SC success: rdata = 1.
- llbit:
  - Set on acceptance of LL (llsc & !write & mem).
  - Cleared on acceptance of any SC, success or fail.
  - Same-cycle accept uses the pre-update llbit.
- Response: lsu_resp_valid_o = entry[head].done. lsu_resp_o carries the head entry fields; uncached=0, wrong_forward=0.
  - Dequeue on valid&ready.
  - Strict program order: a completed younger local entry waits behind an older pending mem entry.
- Latency:
  - Local request: response valid the cycle after acceptance, if at head.
  - Mem request: response valid the cycle after mem_resp_valid_i.
  - No combinational path mem_resp → lsu_resp.
- Simultaneous events:
  - Enqueue, dequeue and mem response may all occur in one cycle; cnt += enq - deq.
  - A full queue with a same-cycle dequeue still reports ready=0 (full uses registered cnt).
  - Pointers wrap modulo OUTSTANDING.
- mem_resp_valid_i with inflight==0 is illegal; the implementation asserts on it in simulation.
- Reset mid-operation discards all entries. The environment must also reset memory so no stale mem_resp arrives.

Test Plan:
- Load byte signed, vaddr=0x1003, mem_rdata=0x80FF_FF11 → resp rdata=0xFFFF_FF80, wid echoed, excp clear; mem_addr_o=0x1000, mem_we_o=0.
- Half load, vaddr=0x2001 → no mem request; resp next cycle with excp=ALE, vaddr=0x2001; a following word load at 0x2004 responds after it.
- LL 0x3000, then SC 0x3000 (llbit=1) → SC issues write, rdata=1. Second SC → no mem request, rdata=0.
- Fill 4 loads with mem_req_ready_i=1 and withhold mem_resp → 5th request sees lsu_req_ready_o=0; responses return in order after 4 mem_resp pulses with lsu_resp_ready_i toggling 1/0.
- dbar after two in-flight stores → lsu_req_ready_o=0 until both mem_resp arrive, accepted the cycle inflight==0, responds third.
- Assert rst_n=0 with 3 entries queued → next cycle lsu_resp_valid_o=0; cnt=0; llbit cleared (subsequent SC fails).
